aoc4_bank_arbiter: RTL and testbench

//  Shares one single-port grid bank between NUM_REQ requesters: the staging

---
 rtl/aoc4_bank_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_aoc4_bank_arbiter.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aoc4_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aoc4_bank_arbiter
// Description : Shares one single-port grid bank between NUM_REQ requesters.
//               Requester 0 is the staging loader; the others are the
//               neighbour-count compute cores. Round-robin grant, a single
//               access in flight, registered memory-side drive, and a
//               one-cycle ack/rdata pulse back to the winner.
// Ports       : clock, reset      - clock and synchronous active-high reset
//               staging           - 1 restricts eligibility to requester 0
//               req/req_we        - per-requester request and write flag
//               req_addr/wdata    - packed per-requester address and data
//               ack/rdata         - one-hot completion pulse, read data
//               busy/grant_id     - access in flight, current/last winner
//               mem_en/we/addr/wdata, mem_rdata - bank port
// Revision    : 1.0 - initial release
// ============================================================================
module aoc4_bank_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 140,
    parameter int MEM_LATENCY = 1,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      staging,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int SUM_W = ID_W + 1;
    localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [CNT_W-1:0]   c_WAIT_INIT = CNT_W'((MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0);
    localparam logic [ID_W-1:0]    c_LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_REQ0      = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_grant;
    logic                r_is_write;
    logic                r_mask_valid;
    logic [CNT_W-1:0]    r_wait;
    logic [NUM_REQ-1:0]  r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_busy;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic [NUM_REQ-1:0]  w_eligible;
    logic                w_found;
    logic [ID_W-1:0]     w_win;
    logic [SUM_W-1:0]    w_cand;
    logic [ID_W-1:0]     w_ptr_next;
    logic                w_to_ack;

    // Round-robin search starting at the pointer. The previous winner is
    // masked for the single IDLE cycle that follows its ack, so a requester
    // that drops req one edge late cannot be issued twice.
    always_comb begin
        w_eligible = staging ? (req & c_REQ0) : req;
        if (r_mask_valid) begin
            w_eligible[r_grant] = 1'b0;
        end
        w_found = 1'b0;
        w_win   = r_ptr;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, r_ptr} + SUM_W'(i);
            if (w_cand >= SUM_W'(NUM_REQ)) begin
                w_cand = w_cand - SUM_W'(NUM_REQ);
            end
            if (!w_found && w_eligible[w_cand[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[ID_W-1:0];
            end
        end
    end

    assign w_ptr_next = (w_win == c_LAST_ID) ? '0 : (w_win + 1'b1);

    // ACK is entered MEM_LATENCY edges after ISSUE began; with a latency of
    // one the WAIT state is skipped entirely.
    assign w_to_ack = ((r_state == S_ISSUE) && (MEM_LATENCY == 1)) ||
                      ((r_state == S_WAIT)  && (r_wait == '0));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_is_write   <= 1'b0;
            r_mask_valid <= 1'b0;
            r_wait       <= '0;
            r_ack        <= '0;
            r_rdata      <= '0;
            r_busy       <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    r_mask_valid <= 1'b0;
                    if (w_found) begin
                        r_state     <= S_ISSUE;
                        r_grant     <= w_win;
                        r_ptr       <= w_ptr_next;
                        r_is_write  <= req_we[w_win];
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= req_we[w_win];
                        r_mem_addr  <= req_addr[w_win*ADDR_W +: ADDR_W];
                        r_mem_wdata <= req_wdata[w_win*DATA_W +: DATA_W];
                        r_busy      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_state  <= S_WAIT;
                    r_wait   <= c_WAIT_INIT;
                end
                S_WAIT: begin
                    r_wait <= r_wait - 1'b1;
                end
                S_ACK: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_mask_valid <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Overrides the ISSUE/WAIT transitions above on the final edge.
            if (w_to_ack) begin
                r_state <= S_ACK;
                r_ack   <= c_REQ0 << r_grant;
                if (!r_is_write) begin
                    r_rdata <= mem_rdata;
                end
            end
        end
    end

    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign grant_id  = r_grant;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_aoc4_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aoc4_bank_arbiter
// Description : Self-checking bench for aoc4_bank_arbiter. Two instances are
//               used: one with a single-cycle bank and one with a three-cycle
//               bank, each attached to a small bank model. Expected acks are
//               queued when requests are driven and popped when acks appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aoc4_bank_arbiter;

    localparam int NR = 3;
    localparam int AW = 8;
    localparam int DW = 140;

    typedef struct {
        int           id;
        bit           rd;
        logic [DW-1:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Instance with MEM_LATENCY = 1
    logic              s1_staging;
    logic [NR-1:0]     s1_req, s1_we;
    logic [NR*AW-1:0]  s1_addr;
    logic [NR*DW-1:0]  s1_wdata;
    logic [NR-1:0]     ack1;
    logic [DW-1:0]     rdata1, mwd1, mrd1;
    logic              busy1, en1, mwe1;
    logic [1:0]        gid1;
    logic [AW-1:0]     maddr1;

    // Instance with MEM_LATENCY = 3
    logic              s3_staging;
    logic [NR-1:0]     s3_req, s3_we;
    logic [NR*AW-1:0]  s3_addr;
    logic [NR*DW-1:0]  s3_wdata;
    logic [NR-1:0]     ack3;
    logic [DW-1:0]     rdata3, mwd3, mrd3, rd0_3, d1_3, d2_3;
    logic              busy3, en3, mwe3;
    logic [1:0]        gid3;
    logic [AW-1:0]     maddr3;

    exp_t q1[$];
    exp_t q3[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    function automatic logic [DW-1:0] row_init(input logic [AW-1:0] a);
        return {{17{a}}, a[3:0] ^ 4'hC};
    endfunction

    aoc4_bank_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) u1 (
        .clock(clock), .reset(reset), .staging(s1_staging), .req(s1_req),
        .req_we(s1_we), .req_addr(s1_addr), .req_wdata(s1_wdata), .ack(ack1),
        .rdata(rdata1), .busy(busy1), .grant_id(gid1), .mem_en(en1),
        .mem_we(mwe1), .mem_addr(maddr1), .mem_wdata(mwd1), .mem_rdata(mrd1)
    );

    aoc4_bank_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3)) u3 (
        .clock(clock), .reset(reset), .staging(s3_staging), .req(s3_req),
        .req_we(s3_we), .req_addr(s3_addr), .req_wdata(s3_wdata), .ack(ack3),
        .rdata(rdata3), .busy(busy3), .grant_id(gid3), .mem_en(en3),
        .mem_we(mwe3), .mem_addr(maddr3), .mem_wdata(mwd3), .mem_rdata(mrd3)
    );

    // Bank models: unwritten rows return row_init(addr).
    logic [DW-1:0] bank1 [0:255];
    logic [DW-1:0] bank3 [0:255];
    logic [255:0]  wr1 = '0;
    logic [255:0]  wr3 = '0;

    always @(posedge clock) begin
        if (en1 && mwe1) begin
            bank1[maddr1] <= mwd1;
            wr1[maddr1]   <= 1'b1;
        end
        if (en3 && mwe3) begin
            bank3[maddr3] <= mwd3;
            wr3[maddr3]   <= 1'b1;
        end
        d1_3 <= rd0_3;
        d2_3 <= d1_3;
    end

    assign mrd1  = wr1[maddr1] ? bank1[maddr1] : row_init(maddr1);
    assign rd0_3 = wr3[maddr3] ? bank3[maddr3] : row_init(maddr3);
    assign mrd3  = d2_3;

    // Scoreboard: every ack must match the oldest queued expectation.
    always @(negedge clock) begin : p_monitor
        exp_t e;
        if (mon_en && ack1 !== '0) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected_u1 got ack=%b want none", ack1);
            end else begin
                e = q1.pop_front();
                if (ack1 !== (3'b001 << e.id)) begin
                    errors++;
                    $display("FAIL ack_id_u1 got ack=%b want id %0d", ack1, e.id);
                end
                if (e.rd) begin
                    checks++;
                    if (rdata1 !== e.data) begin
                        errors++;
                        $display("FAIL rdata_u1 got %h want %h", rdata1, e.data);
                    end
                end
            end
        end
        if (mon_en && ack3 !== '0) begin
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected_u3 got ack=%b want none", ack3);
            end else begin
                e = q3.pop_front();
                if (ack3 !== (3'b001 << e.id)) begin
                    errors++;
                    $display("FAIL ack_id_u3 got ack=%b want id %0d", ack3, e.id);
                end
                if (e.rd) begin
                    checks++;
                    if (rdata3 !== e.data) begin
                        errors++;
                        $display("FAIL rdata_u3 got %h want %h", rdata3, e.data);
                    end
                end
            end
        end
    end

    function automatic void push1(input int id, input bit rd, input logic [DW-1:0] d);
        exp_t e;
        e.id = id; e.rd = rd; e.data = d;
        q1.push_back(e);
    endfunction

    function automatic void push3(input int id, input bit rd, input logic [DW-1:0] d);
        exp_t e;
        e.id = id; e.rd = rd; e.data = d;
        q3.push_back(e);
    endfunction

    task automatic set1(input int slot, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        s1_we[slot] = we;
        s1_addr[slot*AW +: AW] = a;
        s1_wdata[slot*DW +: DW] = d;
    endtask

    task automatic set3(input int slot, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        s3_we[slot] = we;
        s3_addr[slot*AW +: AW] = a;
        s3_wdata[slot*DW +: DW] = d;
    endtask

    task automatic test_reset();
        checks++;
        if ({ack1, busy1, en1, mwe1, gid1} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl_u1 got %b want 0", {ack1, busy1, en1, mwe1, gid1});
        end
        checks++;
        if ({maddr1, mwd1, rdata1} !== '0) begin
            errors++;
            $display("FAIL reset_data_u1 got addr=%h wdata=%h rdata=%h want 0", maddr1, mwd1, rdata1);
        end
        checks++;
        if ({ack3, busy3, en3, mwe3, gid3} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl_u3 got %b want 0", {ack3, busy3, en3, mwe3, gid3});
        end
        checks++;
        if ({maddr3, mwd3, rdata3} !== '0) begin
            errors++;
            $display("FAIL reset_data_u3 got addr=%h wdata=%h rdata=%h want 0", maddr3, mwd3, rdata3);
        end
    endtask

    task automatic test_single_write();
        logic [DW-1:0] pat;
        int ack_at, en_n;
        pat = {{17{8'hA5}}, 4'hA};
        // Write req0 row 5
        @(negedge clock);
        set1(0, 1'b1, 8'd5, pat);
        push1(0, 1'b0, '0);
        s1_req = 3'b001;
        ack_at = 0; en_n = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (k == 1) begin
                checks++;
                if ({en1, mwe1, maddr1, busy1, gid1} !== {1'b1, 1'b1, 8'd5, 1'b1, 2'd0}) begin
                    errors++;
                    $display("FAIL write_issue got en=%b we=%b addr=%0d busy=%b gid=%0d want 1 1 5 1 0",
                             en1, mwe1, maddr1, busy1, gid1);
                end
                checks++;
                if (mwd1 !== pat) begin
                    errors++;
                    $display("FAIL write_wdata got %h want %h", mwd1, pat);
                end
            end
            if (en1) en_n++;
            if (ack1 !== '0 && ack_at == 0) begin
                ack_at = k;
                s1_req = 3'b000;
            end
        end
        checks++;
        if (ack_at != 2) begin
            errors++;
            $display("FAIL write_latency got %0d want 2", ack_at);
        end
        checks++;
        if (en_n != 1) begin
            errors++;
            $display("FAIL write_en_cycles got %0d want 1", en_n);
        end
        checks++;
        if (wr1[5] !== 1'b1 || bank1[5] !== pat) begin
            errors++;
            $display("FAIL bank_row5 got %h want %h", bank1[5], pat);
        end
        // Read row 5 back through the arbiter
        set1(0, 1'b0, 8'd5, '0);
        push1(0, 1'b1, pat);
        s1_req = 3'b001;
        ack_at = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (ack1 !== '0 && ack_at == 0) begin
                ack_at = k;
                s1_req = 3'b000;
            end
        end
        checks++;
        if (ack_at != 2) begin
            errors++;
            $display("FAIL read_latency got %0d want 2", ack_at);
        end
    endtask

    task automatic test_round_robin();
        int nacks, last;
        set1(1, 1'b0, 8'd10, '0);
        set1(2, 1'b0, 8'd20, '0);
        push1(1, 1'b1, row_init(8'd10));
        push1(2, 1'b1, row_init(8'd20));
        push1(1, 1'b1, row_init(8'd10));
        push1(2, 1'b1, row_init(8'd20));
        s1_req = 3'b110;
        nacks = 0; last = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (ack1 !== '0) begin
                nacks++;
                if (nacks > 1) begin
                    checks++;
                    if (k - last != 3) begin
                        errors++;
                        $display("FAIL rr_spacing got %0d want 3", k - last);
                    end
                end
                last = k;
            end
            if (nacks == 4) break;
        end
        s1_req = 3'b000;
        checks++;
        if (nacks != 4) begin
            errors++;
            $display("FAIL rr_ack_count got %0d want 4", nacks);
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_staging();
        int nacks;
        set1(0, 1'b0, 8'd30, '0);
        push1(0, 1'b1, row_init(8'd30));
        push1(0, 1'b1, row_init(8'd30));
        push1(0, 1'b1, row_init(8'd30));
        push1(1, 1'b1, row_init(8'd10));
        push1(2, 1'b1, row_init(8'd20));
        s1_staging = 1'b1;
        s1_req = 3'b111;
        nacks = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (s1_staging && busy1) begin
                checks++;
                if (gid1 !== 2'd0) begin
                    errors++;
                    $display("FAIL staging_grant got %0d want 0", gid1);
                end
            end
            if (ack1 !== '0) begin
                nacks++;
                if (nacks == 3) s1_staging = 1'b0;
                if (nacks == 5) begin
                    s1_req = 3'b000;
                    break;
                end
            end
        end
        s1_req = 3'b000;
        checks++;
        if (nacks != 5) begin
            errors++;
            $display("FAIL staging_ack_count got %0d want 5", nacks);
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_read_latency3();
        int ack_at, nb, ne;
        @(negedge clock);
        set3(2, 1'b0, 8'd139, '0);
        push3(2, 1'b1, row_init(8'd139));
        s3_req = 3'b100;
        ack_at = 0; nb = 0; ne = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) begin
                checks++;
                if ({maddr3, mwe3, gid3} !== {8'd139, 1'b0, 2'd2}) begin
                    errors++;
                    $display("FAIL l3_issue got addr=%0d we=%b gid=%0d want 139 0 2", maddr3, mwe3, gid3);
                end
            end
            if (busy3) nb++;
            if (en3) ne++;
            if (ack3 !== '0 && ack_at == 0) begin
                ack_at = k;
                s3_req = 3'b000;
            end
        end
        checks++;
        if (ack_at != 4) begin
            errors++;
            $display("FAIL l3_latency got %0d want 4", ack_at);
        end
        checks++;
        if (nb != 4) begin
            errors++;
            $display("FAIL l3_busy_cycles got %0d want 4", nb);
        end
        checks++;
        if (ne != 1) begin
            errors++;
            $display("FAIL l3_en_cycles got %0d want 1", ne);
        end
    endtask

    task automatic test_reset_mid_access();
        int nacks;
        @(negedge clock);
        set3(1, 1'b0, 8'd60, '0);
        s3_req = 3'b010;
        @(negedge clock);               // ISSUE for req1
        set3(0, 1'b0, 8'd40, '0);
        s3_req = 3'b011;
        @(negedge clock);               // WAIT
        checks++;
        if ({busy3, en3} !== 2'b10) begin
            errors++;
            $display("FAIL pre_reset_wait got busy=%b en=%b want 1 0", busy3, en3);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({ack3, busy3, en3} !== '0) begin
            errors++;
            $display("FAIL reset_abort got ack=%b busy=%b en=%b want 0", ack3, busy3, en3);
        end
        reset = 1'b0;
        push3(0, 1'b1, row_init(8'd40));
        push3(1, 1'b1, row_init(8'd60));
        nacks = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (k == 1) begin
                checks++;
                if ({busy3, en3, gid3} !== {1'b1, 1'b1, 2'd0}) begin
                    errors++;
                    $display("FAIL post_reset_grant got busy=%b en=%b gid=%0d want 1 1 0", busy3, en3, gid3);
                end
            end
            if (ack3 !== '0) begin
                nacks++;
                s3_req = s3_req & ~ack3;
                if (nacks == 2) break;
            end
        end
        s3_req = 3'b000;
        checks++;
        if (nacks != 2) begin
            errors++;
            $display("FAIL post_reset_ack_count got %0d want 2", nacks);
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_late_drop();
        logic [DW-1:0] pat;
        int ack_at, ne;
        pat = {{35{4'h3}}};
        @(negedge clock);
        set1(0, 1'b1, 8'd50, pat);
        push1(0, 1'b0, '0);
        s1_req = 3'b001;
        ack_at = 0; ne = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (en1) ne++;
            if (ack1 !== '0 && ack_at == 0) ack_at = k;
            if (ack_at != 0 && k == ack_at + 2) begin
                checks++;
                if (busy1 !== 1'b0) begin
                    errors++;
                    $display("FAIL late_drop_reissue got busy=%b want 0", busy1);
                end
                s1_req = 3'b000;
            end
        end
        s1_req = 3'b000;
        checks++;
        if (ne != 1) begin
            errors++;
            $display("FAIL late_drop_en_cycles got %0d want 1", ne);
        end
        checks++;
        if (ack_at != 2) begin
            errors++;
            $display("FAIL late_drop_latency got %0d want 2", ack_at);
        end
        checks++;
        if (wr1[50] !== 1'b1 || bank1[50] !== pat) begin
            errors++;
            $display("FAIL bank_row50 got %h want %h", bank1[50], pat);
        end
    endtask

    task automatic test_drain();
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL pending_u1 got %0d want 0", q1.size());
        end
        checks++;
        if (q3.size() != 0) begin
            errors++;
            $display("FAIL pending_u3 got %0d want 0", q3.size());
        end
    endtask

    initial begin
        s1_staging = 1'b0; s1_req = '0; s1_we = '0; s1_addr = '0; s1_wdata = '0;
        s3_staging = 1'b0; s3_req = '0; s3_we = '0; s3_addr = '0; s3_wdata = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b0;
        mon_en = 1'b1;
        test_single_write();
        test_round_robin();
        test_staging();
        test_read_latency3();
        test_reset_mid_access();
        test_late_drop();
        repeat (3) @(negedge clock);
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
